pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the load and flush enables of the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Resolves load-use stalls, taken-branch squashes, memory wait states and ECALL/EBREAK halt-with-drain.
//  Sits beside the hazard unit. Drives every pipeline register's load pin and the flush (bubble) muxes.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles after halt_req that EX/MEM/WB keep advancing before HALT (1..15)
//  CNT_W         16  width of stall_cnt performance counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous reset, active-low (0 = reset)
//  ld_use_haz   in   1      ID instr needs a load result now in EX
//  br_taken     in   1      branch/jump resolved taken in MEM stage; PC target valid this cycle
//  mem_ready    in   1      shared instr/data memory completes access this cycle
//  halt_req     in   1      ECALL/EBREAK decoded in ID
//  pc_load      out  1      PC register load enable
//  ifid_load    out  1      IF/ID load enable
//  idex_load    out  1      ID/EX load enable
//  exmem_load   out  1      EX/MEM load enable
//  memwb_load   out  1      MEM/WB load enable
//  ifid_flush   out  1      IF/ID loads NOP
//  idex_flush   out  1      ID/EX loads NOP
//  exmem_flush  out  1      EX/MEM loads NOP
//  halted       out  1      core halted; registered
//  stall_cnt    out  CNT_W  count of cycles with pc_load=0 since reset; saturates at all-ones
// BEHAVIOUR
//  States: RUN, MEMWAIT, DRAIN, HALT. State, drain counter, halted, stall_cnt are flops; enables are combinational.
//  Reset (rst=0, async): state=RUN, drain_cnt=0, halted=0, stall_cnt=0; all load/flush outputs forced 0 while rst=0.
//  Input priority within a cycle: mem_ready=0 > br_taken > halt_req > ld_use_haz.
//  RUN, mem_ready=0: all loads 0, all flushes 0 (freeze); next=MEMWAIT.
//  RUN, br_taken: all loads 1; ifid_flush=idex_flush=exmem_flush=1; simultaneous ld_use_haz/halt_req ignored (squashed).
//  RUN, halt_req: pc_load=0, ifid_load=1, ifid_flush=1, others load 1; next=DRAIN, drain_cnt=DRAIN_CYCLES-1.
//  RUN, ld_use_haz: pc_load=0, ifid_load=0, idex_load=1, idex_flush=1, exmem/memwb load 1 (one bubble). Exactly 1 stall
//   cycle per assertion edge is the hazard unit's job; controller stalls every cycle ld_use_haz=1.
//  RUN, none: all loads 1, flushes 0.
//  MEMWAIT: freeze (all 0) while mem_ready=0; on mem_ready=1 apply RUN rules to the other inputs this cycle, next=RUN
//   (or DRAIN if halt_req applied).
//  DRAIN: pc_load=0, ifid_load=1, ifid_flush=1, idex_load=1, idex_flush=1, exmem/memwb load 1. mem_ready=0 freezes
//   all and holds drain_cnt. br_taken/ld_use_haz/halt_req ignored. drain_cnt==0 -> next=HALT, else decrement.
//  HALT: all loads 0, flushes 0; halted=1 from first HALT cycle; only rst exits.
//  stall_cnt: +1 every clock with pc_load=0 outside reset (including DRAIN/HALT); holds at 2^CNT_W-1.
//  Reset asserted mid-stall/drain: immediate return to RUN values; no partial state retained.
// TESTING
//  Free run 10 cycles, no hazards -> all loads 1, flushes 0, stall_cnt=0.
//  ld_use_haz=1 one cycle -> that cycle pc_load=0, ifid_load=0, idex_flush=1; next cycle all loads 1; stall_cnt=1.
//  br_taken=1 with ld_use_haz=1 same cycle -> pc_load=1, ifid/idex/exmem_flush=1; stall_cnt unchanged.
//  mem_ready=0 for 4 cycles then 1 -> 4 cycles all outputs 0, stall_cnt=4, RUN resumes with loads 1.
//  halt_req=1, DRAIN_CYCLES=3 -> 1 RUN-halt cycle + 3 DRAIN cycles, halted=1 on 5th clock, loads 0 thereafter.
//  rst=0 in DRAIN, mid-cycle -> outputs 0 immediately, halted=0, stall_cnt=0; after release, free run resumes.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the hazard unit and the pipeline load/flush controller.
// The master side drives hazard requests; the slave side drives register enables.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ld_use_haz;
  logic             br_taken;
  logic             mem_ready;
  logic             halt_req;
  logic             pc_load;
  logic             ifid_load;
  logic             idex_load;
  logic             exmem_load;
  logic             memwb_load;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ld_use_haz, br_taken, mem_ready, halt_req,
    input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
    input  ifid_flush, idex_flush, exmem_flush, halted, stall_cnt
  );

  modport slave (
    input  ld_use_haz, br_taken, mem_ready, halt_req,
    output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
    output ifid_flush, idex_flush, exmem_flush, halted, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register load/flush sequencer: stalls, squashes, memory waits
// and halt-with-drain, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN,
    MEMWAIT,
    DRAIN,
    HALT
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // {pc, ifid, idex, exmem, memwb} and {ifid, idex, exmem}
  logic [4:0] ld_c;
  logic [2:0] fl_c;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    ld_c    = 5'b00000;
    fl_c    = 3'b000;
    unique case (state_q)
      RUN, MEMWAIT: begin
        if (!bus.mem_ready) begin
          state_d = MEMWAIT;
        end else if (bus.br_taken) begin
          ld_c    = 5'b11111;
          fl_c    = 3'b111;
          state_d = RUN;
        end else if (bus.halt_req) begin
          ld_c    = 5'b01111;
          fl_c    = 3'b100;
          state_d = DRAIN;
          drain_d = 4'(DRAIN_CYCLES - 1);
        end else if (bus.ld_use_haz) begin
          ld_c    = 5'b00111;
          fl_c    = 3'b010;
          state_d = RUN;
        end else begin
          ld_c    = 5'b11111;
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (bus.mem_ready) begin
          ld_c = 5'b01111;
          fl_c = 3'b110;
          if (drain_q == 4'd0) state_d = HALT;
          else drain_d = drain_q - 4'd1;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = RUN;
    endcase
  end

  assign halted_d = (state_d == HALT);
  assign stall_d  = (!ld_c[4] && stall_q != {CNT_W{1'b1}})
                  ? stall_q + 1'b1 : stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      drain_q  <= 4'd0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  // Enables are held low for the whole time reset is asserted.
  assign bus.pc_load     = rst & ld_c[4];
  assign bus.ifid_load   = rst & ld_c[3];
  assign bus.idex_load   = rst & ld_c[2];
  assign bus.exmem_load  = rst & ld_c[1];
  assign bus.memwb_load  = rst & ld_c[0];
  assign bus.ifid_flush  = rst & fl_c[2];
  assign bus.idex_flush  = rst & fl_c[1];
  assign bus.exmem_flush = rst & fl_c[0];
  assign bus.halted      = halted_q;
  assign bus.stall_cnt   = stall_q;

endmodule
